// File: rtl/fe_ctrl_pkg.sv
// ============================================================================
// Module   : fe_ctrl_pkg
// Brief    : Shared state encoding and PC-mux select codes for the fetch sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PRIME = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fe_state_e;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

    localparam int FLUSH_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/fe_ctrl_sat_cnt.sv
// ============================================================================
// Module   : fe_ctrl_sat_cnt
// Brief    : Saturating up-counter with increment enable and asynchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fe_ctrl_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/fe_ctrl.sv
// ============================================================================
// Module   : fe_ctrl
// Brief    : Fetch-stage sequencer: memory priming, load-use stalls, branch/jump
//            redirect with bubble insertion, and sticky HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fe_ctrl
    import fe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES     = 2,
    parameter int JMP_FLUSH_CYCLES = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        br_taken,
    input  logic        jmp,
    input  logic        halt,
    output logic        PC_WR_EN,
    output logic        FE_LATCH_WR,
    output logic        instr_mem_en,
    output logic [1:0]  ctr_sig,
    output logic        fe_flush,
    output logic [2:0]  ctrl_state,
    output logic [15:0] stall_cycles
);

    localparam logic [FLUSH_CNT_W-1:0] BR_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] JMP_LOAD = FLUSH_CNT_W'(JMP_FLUSH_CYCLES - 1);

    fe_state_e              state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   stall_inc;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        PC_WR_EN     = 1'b0;
        FE_LATCH_WR  = 1'b0;
        instr_mem_en = 1'b0;
        ctr_sig      = PC_SEL_SEQ;
        fe_flush     = 1'b0;
        stall_inc    = 1'b0;

        case (state_q)
            ST_PRIME: begin
                instr_mem_en = 1'b1;
                fe_flush     = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (br_taken) begin
                    {PC_WR_EN, FE_LATCH_WR, instr_mem_en, fe_flush} = 4'b1111;
                    ctr_sig     = PC_SEL_BR;
                    flush_cnt_d = BR_LOAD;
                    state_d     = (BR_LOAD == '0) ? ST_RUN : ST_FLUSH;
                end else if (jmp) begin
                    {PC_WR_EN, FE_LATCH_WR, instr_mem_en, fe_flush} = 4'b1111;
                    ctr_sig     = PC_SEL_JMP;
                    flush_cnt_d = JMP_LOAD;
                    state_d     = (JMP_LOAD == '0) ? ST_RUN : ST_FLUSH;
                end else if (halt) begin
                    // Halting cycle looks like a stall but is not counted as one.
                    state_d = ST_HALT;
                end else if (stall_req) begin
                    stall_inc = 1'b1;
                    state_d   = ST_STALL;
                end else begin
                    {PC_WR_EN, FE_LATCH_WR, instr_mem_en} = 3'b111;
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                {PC_WR_EN, FE_LATCH_WR, instr_mem_en, fe_flush} = 4'b1111;
                if (br_taken) begin
                    ctr_sig     = PC_SEL_BR;
                    flush_cnt_d = BR_LOAD;
                    state_d     = (BR_LOAD == '0) ? ST_RUN : ST_FLUSH;
                end else if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    // The count holds the number of FLUSH cycles still to run.
                    flush_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase

        if (reset) begin
            PC_WR_EN     = 1'b0;
            FE_LATCH_WR  = 1'b0;
            instr_mem_en = 1'b0;
            ctr_sig      = PC_SEL_SEQ;
            fe_flush     = 1'b1;
            stall_inc    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PRIME;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fe_ctrl_sat_cnt #(
        .WIDTH (16)
    ) u_stall_cnt (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_inc   (stall_inc),
        .o_count (stall_cycles)
    );

    assign ctrl_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fe_ctrl.sv
// ============================================================================
// Module   : tb_fe_ctrl
// Brief    : Self-checking scoreboard bench for the fetch-stage sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fe_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_req, br_taken, jmp, halt;
    logic        PC_WR_EN, FE_LATCH_WR, instr_mem_en, fe_flush;
    logic [1:0]  ctr_sig;
    logic [2:0]  ctrl_state;
    logic [15:0] stall_cycles;

    int n_err;
    int n_chk;

    typedef struct packed {
        logic        pc;
        logic        fe;
        logic        mem;
        logic [1:0]  ctr;
        logic        fl;
        logic [2:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    fe_ctrl #(
        .FLUSH_CYCLES     (2),
        .JMP_FLUSH_CYCLES (1)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .stall_req    (stall_req),
        .br_taken     (br_taken),
        .jmp          (jmp),
        .halt         (halt),
        .PC_WR_EN     (PC_WR_EN),
        .FE_LATCH_WR  (FE_LATCH_WR),
        .instr_mem_en (instr_mem_en),
        .ctr_sig      (ctr_sig),
        .fe_flush     (fe_flush),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic pc, input logic fe, input logic mem,
                                input logic [1:0] ctr, input logic fl,
                                input logic [2:0] st, input logic [15:0] cnt);
        exp_t e;
        e.pc = pc; e.fe = fe; e.mem = mem; e.ctr = ctr;
        e.fl = fl; e.st = st; e.cnt = cnt;
        return e;
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, then pop and compare mid-cycle.
    task automatic step(input string tag, input logic r, input logic s, input logic b,
                        input logic j, input logic h, input exp_t e);
        exp_t x;
        reset = r; stall_req = s; br_taken = b; jmp = j; halt = h;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb_q.pop_front();
            chk({tag, ".pc_wr"},  {31'd0, PC_WR_EN},     {31'd0, x.pc});
            chk({tag, ".fe_wr"},  {31'd0, FE_LATCH_WR},  {31'd0, x.fe});
            chk({tag, ".mem_en"}, {31'd0, instr_mem_en}, {31'd0, x.mem});
            chk({tag, ".ctr"},    {30'd0, ctr_sig},      {30'd0, x.ctr});
            chk({tag, ".flush"},  {31'd0, fe_flush},     {31'd0, x.fl});
            chk({tag, ".state"},  {29'd0, ctrl_state},   {29'd0, x.st});
            chk({tag, ".stcnt"},  {16'd0, stall_cycles}, {16'd0, x.cnt});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;

        // States: 0 PRIME, 1 RUN, 2 STALL, 3 FLUSH, 4 HALT
        step("rst",     1, 0, 0, 0, 0, mk(0, 0, 0, 2'd0, 1, 3'd0, 16'd0));
        step("prime",   0, 0, 0, 0, 0, mk(0, 0, 1, 2'd0, 1, 3'd0, 16'd0));
        step("run0",    0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd0));

        step("stall1",  0, 1, 0, 0, 0, mk(0, 0, 0, 2'd0, 0, 3'd1, 16'd0));
        step("stall2",  0, 1, 0, 0, 0, mk(0, 0, 0, 2'd0, 0, 3'd2, 16'd1));
        step("stall3",  0, 1, 0, 0, 0, mk(0, 0, 0, 2'd0, 0, 3'd2, 16'd2));
        step("unstall", 0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd2, 16'd3));
        step("run1",    0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd3));

        step("br",      0, 0, 1, 0, 0, mk(1, 1, 1, 2'd1, 1, 3'd1, 16'd3));
        step("brfl",    0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 1, 3'd3, 16'd3));
        step("brdone",  0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd3));

        step("jmp",     0, 0, 0, 1, 0, mk(1, 1, 1, 2'd2, 1, 3'd1, 16'd3));
        step("jmpdone", 0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd3));

        step("all3",    0, 1, 1, 1, 0, mk(1, 1, 1, 2'd1, 1, 3'd1, 16'd3));
        step("rebr",    0, 0, 1, 0, 0, mk(1, 1, 1, 2'd1, 1, 3'd3, 16'd3));
        step("flstj",   0, 1, 0, 1, 0, mk(1, 1, 1, 2'd0, 1, 3'd3, 16'd3));
        step("rerun",   0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd3));

        step("halt",    0, 1, 0, 0, 1, mk(0, 0, 0, 2'd0, 0, 3'd1, 16'd3));
        step("hlt_br",  0, 0, 1, 0, 0, mk(0, 0, 0, 2'd0, 0, 3'd4, 16'd3));
        step("hlt_jmp", 0, 0, 0, 1, 0, mk(0, 0, 0, 2'd0, 0, 3'd4, 16'd3));
        step("hlt_idl", 0, 0, 0, 0, 0, mk(0, 0, 0, 2'd0, 0, 3'd4, 16'd3));
        step("hlt_rst", 1, 0, 0, 0, 0, mk(0, 0, 0, 2'd0, 1, 3'd0, 16'd0));
        step("prime2",  0, 0, 0, 0, 0, mk(0, 0, 1, 2'd0, 1, 3'd0, 16'd0));
        step("run2",    0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd0));

        stall_req = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        step("sat",     0, 1, 0, 0, 0, mk(0, 0, 0, 2'd0, 0, 3'd2, 16'hFFFF));
        step("satrst",  1, 1, 0, 0, 0, mk(0, 0, 0, 2'd0, 1, 3'd0, 16'd0));
        step("prime3",  0, 0, 0, 0, 0, mk(0, 0, 1, 2'd0, 1, 3'd0, 16'd0));
        step("run3",    0, 0, 0, 0, 0, mk(1, 1, 1, 2'd0, 0, 3'd1, 16'd0));

        if (sb_q.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_drain: %0d left expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
